// File: rtl/cla_mw_sequencer.sv
// Multi-word add/subtract sequencer driving one external W-bit CLA,
// least-significant word first, with a registered inter-word carry.
module cla_mw_sequencer #(
    parameter int W      = 16,
    parameter int NWORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NWORDS*W-1:0] in_a,
    input  logic [NWORDS*W-1:0] in_b,
    input  logic                in_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NWORDS*W-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                busy,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    output logic                add_cin,
    input  logic [W-1:0]        add_sum,
    input  logic                add_cout
);

    localparam int N  = NWORDS * W;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [N-1:0]    sum_reg;
    logic [N-1:0]    sum_nxt;
    logic [N-1:0]    res_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic            accept;
    logic            last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == IDLE): if (in_valid)  state_nxt = RUN;
            (state == RUN):  if (last)      state_nxt = DONE;
            (state == DONE): if (out_ready) state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Final result is assembled with the top word straight from the adder,
    // so the visible result only changes on completion.
    always_comb begin
        sum_nxt = sum_reg;
        sum_nxt[idx*W +: W] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            res_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg <= sum_nxt;
            carry   <= add_cout;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) begin
                res_reg  <= sum_nxt;
                cout_reg <= add_cout;
                ovf_reg  <= (a_reg[N-1] == b_reg[N-1]) &&
                            (add_sum[W-1] != a_reg[N-1]);
            end
        end
    end

    always_comb begin
        in_ready  = !rst && (state == IDLE);
        out_valid = !rst && (state == DONE);
        busy      = !rst && (state == RUN || state == DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (!rst && state == RUN) begin
            add_a   = a_reg[idx*W +: W];
            add_b   = b_reg[idx*W +: W];
            add_cin = carry;
        end
        out_sum  = rst ? '0 : res_reg;
        out_cout = !rst && cout_reg;
        out_ovf  = !rst && ovf_reg;
    end

endmodule

// File: tb/tb_cla_mw_sequencer.sv
// Scoreboard bench for cla_mw_sequencer: directed test-plan cases plus
// random operations checked against an arithmetic reference model.
module tb_cla_mw_sequencer;

    localparam int W = 16;
    localparam int NW = 4;
    localparam int N = W * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          in_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;

    cla_mw_sequencer #(.W(W), .NWORDS(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // The external adder: plain W-bit addition with carry.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   stop_rand = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        exp_t e;
        logic [N:0] u;
        logic signed [N:0] s;
        if (sub) begin
            u = {1'b0, a} - {1'b0, b};
            s = $signed({a[N-1], a}) - $signed({b[N-1], b});
            e.cout = (a >= b);
        end else begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[N-1], a}) + $signed({b[N-1], b});
            e.cout = u[N];
        end
        e.sum = u[N-1:0];
        e.ovf = (s[N] != s[N-1]);
        return e;
    endfunction

    // Monitor: pops on every result handshake, checks hold under backpressure.
    logic          held = 0;
    logic [N-1:0]  h_sum;
    logic          h_cout;
    logic          h_ovf;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("in_ready_while_done", in_ready, 0);
            if (held) begin
                chk("hold_sum", out_sum, h_sum);
                chk("hold_cout", out_cout, h_cout);
                chk("hold_ovf", out_ovf, h_ovf);
            end
            if (out_ready) begin
                held = 0;
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_sum", out_sum, e.sum);
                    chk("out_cout", out_cout, e.cout);
                    chk("out_ovf", out_ovf, e.ovf);
                end
            end else begin
                held = 1;
                h_sum = out_sum;
                h_cout = out_cout;
                h_ovf = out_ovf;
            end
        end else begin
            held = 0;
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sub, input bit push);
        bit rdy;
        bit done;
        done = 0;
        @(posedge clk); #1;
        in_valid = 1; in_a = a; in_b = b; in_sub = sub;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                if (push) sb.push_back(model(a, b, sub));
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
        #1;
        in_valid = 0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_sub = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("wait_out_valid", seen, 1);
    endtask

    logic [N-1:0] ra, rb;
    logic [3:0]   cin_seq;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_out_sum", out_sum, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        // Test 1 with latency and carry chain inspection
        issue(64'h0000_0000_0000_FFFF, 64'h1, 0, 1);
        cin_seq = 4'b0010;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            chk("t1_add_cin", add_cin, cin_seq[k]);
            chk("t1_busy", busy, 1);
            chk("t1_no_valid_yet", out_valid, 0);
        end
        @(negedge clk);
        chk("t1_latency_valid", out_valid, 1);
        drain();

        // Test 2
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 1);
        cin_seq = 4'b1110;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            chk("t2_add_cin", add_cin, cin_seq[k]);
        end
        drain();

        // Tests 3 and 4
        issue(64'h5, 64'h7, 1, 1);
        issue(64'h7, 64'h5, 1, 1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 1);
        issue(64'h8000_0000_0000_0000, 64'h1, 1, 1);
        drain();

        // Test 5: backpressure with a competing request held valid
        @(posedge clk); #1 out_ready = 0;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 1);
        wait_valid();
        fork
            issue(64'hAAAA_0000_5555_FFFF, 64'h5555_FFFF_AAAA_0001, 1, 1);
        join_none
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_ready_after_hs", in_ready, 1);
        chk("t5_valid_low_after_hs", out_valid, 0);
        wait fork;
        drain();

        // Test 6: reset in RUN with idx==2 aborts the operation
        issue(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("t6_rst_add_a", add_a, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t6_idle_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_add_a", add_a, 0);
        chk("t6_add_b", add_b, 0);
        chk("t6_add_cin", add_cin, 0);
        chk("t6_busy", busy, 0);
        issue(64'h1, 64'h1, 0, 1);
        drain();

        // Random operations with random sink backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    if ($urandom_range(0, 5) == 0) ra = {N{1'b1}};
                    if ($urandom_range(0, 5) == 0) rb = {1'b1, {(N-1){1'b0}}};
                    if ($urandom_range(0, 7) == 0) rb = ra;
                    issue(ra, rb, $urandom_range(0, 1), 1);
                end
                drain();
                stop_rand = 1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1;
        repeat (NW + 4) @(negedge clk);
        chk("final_queue_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_mw_sequencer.md
Name: cla_mw_sequencer

Overview:
- Multi-word add/subtract sequencer that time-multiplexes one external W-bit carry-look-ahead adder across NWORDS words, least-significant word first.
- Chains the carry through a registered carry bit from one word to the next.
- Sits between a valid/ready operand source and a valid/ready result sink. Lets the team do 64-bit (or wider) arithmetic with the existing 16-bit CLA instance, without duplicating adder hardware.

Parameters:
- W, 16, word width; must equal the width of the attached adder.
- NWORDS, 4, number of words per operand; must be at least 2. Operand width is NWORDS*W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  sequencer can accept a request.
- in_a  in  NWORDS*W  operand A.
- in_b  in  NWORDS*W  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_sum  out  NWORDS*W  result.
- out_cout  out  1  final carry out; for subtract this is 1 when A>=B unsigned (no borrow).
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high when the state is RUN or DONE.
- add_a  out  W  to adder A.
- add_b  out  W  to adder B.
- add_cin  out  1  to adder Cin.
- add_sum  in  W  from adder Sum; combinational, valid in the same cycle.
- add_cout  in  1  from adder Cout; combinational, valid in the same cycle.

Behaviour:
- Reset state:
  - While rst is high: state=IDLE, idx=0, carry=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=0.
  - add_a, add_b and add_cin are 0 while rst is high.
- Reset mid-operation: rst in any state aborts the operation on the next edge. The partial result is discarded; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 (when rst is low). Adder ports are driven to 0.
  - On the in_valid && in_ready edge, latch:
    - a_reg=in_a
    - b_reg = in_sub ? ~in_b : in_b
    - carry=in_sub
    - idx=0
  - Then go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally drive: add_a=a_reg word idx (bits idx*W+W-1 : idx*W), add_b=b_reg word idx, add_cin=carry.
  - On each edge: sum_reg word idx <= add_sum; carry <= add_cout; idx <= idx+1.
  - When idx==NWORDS-1, the same edge additionally:
    - loads out_cout=add_cout;
    - loads out_ovf=(a_reg MSB == b_reg MSB) && (add_sum MSB != a_reg MSB);
    - goes to DONE.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - in_valid is ignored.
  - On the out_valid && out_ready edge go to IDLE: out_valid=0 on the next cycle, and in_ready=1 that same next cycle.
- Latency: request accepted at edge T; RUN occupies cycles T+1 .. T+NWORDS; out_valid is first high in the cycle after edge T+NWORDS.
  - If out_ready is already high, the result is consumed on edge T+NWORDS+1.
  - Peak throughput is one operation per NWORDS+2 cycles; there is no back-to-back accept while DONE.
- Arithmetic rules:
  - Subtraction is A + ~B + 1. The +1 enters as the initial carry, on word 0 only.
  - out_sum is the sum modulo 2^(NWORDS*W).
- idx is a ceil(log2(NWORDS))-bit counter and never exceeds NWORDS-1; wrap-around never occurs.
- in_a, in_b and in_sub are sampled only on the accept edge. Later changes have no effect on the operation in progress.
- out_sum, out_cout and out_ovf retain their last values after the handshake until the next completion or reset.

Test Plan:
All cases use NWORDS=4 and W=16.
1. Add 0x0000_0000_0000_FFFF + 0x0000_0000_0000_0001 -> out_sum=0x0000_0000_0001_0000, out_cout=0, out_ovf=0. out_valid is first high 5 cycles after the accept edge. add_cin sequence is 0,1,0,0 across the RUN cycles.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> out_sum=0, out_cout=1, out_ovf=0. add_cin is 0,1,1,1.
3. Subtract 0x5 - 0x7 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0, out_ovf=0. Subtract 0x7 - 0x5 -> out_sum=0x2, out_cout=1.
4. Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_cout=0. Subtract 0x8000_0000_0000_0000 - 0x1 -> out_sum=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
5. Backpressure:
   - Hold out_ready=0 for 3 cycles while DONE, and drive in_valid=1 with new operands throughout.
   - Required: out_* stable, in_ready=0, no accept.
   - Raise out_ready: handshake completes; in_ready=1 the next cycle; the second request is accepted and gives the correct result.
6. Assert rst for 1 cycle while RUN with idx=2:
   - Next cycle: state IDLE, out_valid=0, add ports=0, no out_valid for the aborted operation.
   - A new add 0x1+0x1 then completes with out_sum=0x2.
